// File: rtl/mac_pkg.sv
// Shared widths and result conversion for the systolic multiply-accumulate PE.
package mac_pkg;

    localparam int DATA_W_D = 32;
    localparam int ACC_W_D  = 64;
    localparam int OUT_W_D  = 32;
    localparam int CONV_W   = 128;

    typedef struct packed {
        logic              clamped;
        logic [CONV_W-1:0] value;
    } conv_t;

    // The caller sign-extends its sum to CONV_W and keeps the low out_w bits of value.
    function automatic conv_t sat_conv(input logic signed [CONV_W-1:0] sum,
                                       input int out_w,
                                       input bit saturate);
        logic signed [CONV_W-1:0] max_v;
        logic signed [CONV_W-1:0] min_v;
        conv_t r;
        max_v     = (128'sd1 <<< (out_w - 1)) - 128'sd1;
        min_v     = -max_v - 128'sd1;
        r.clamped = 1'b0;
        r.value   = sum;
        if (saturate) begin
            if (sum > max_v) begin
                r.clamped = 1'b1;
                r.value   = max_v;
            end else if (sum < min_v) begin
                r.clamped = 1'b1;
                r.value   = min_v;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_pe_sys_mul_pipe.sv
// Signed multiplier followed by MUL_STAGES registers carrying product, valid and last.
module mac_mul_pipe #(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DATA_W-1:0]     w_in,
    input  logic [DATA_W-1:0]     im_in,
    output logic [2*DATA_W-1:0]   prod,
    output logic                  mv,
    output logic                  ml
);

    logic signed [2*DATA_W-1:0] mul;
    logic [2*DATA_W-1:0]        prod_q [MUL_STAGES];
    logic [MUL_STAGES-1:0]      valid_q;
    logic [MUL_STAGES-1:0]      last_q;

    assign mul = (2*DATA_W)'($signed(w_in)) * (2*DATA_W)'($signed(im_in));

    // clr kills every beat in flight, including one being presented right now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) prod_q[i] <= '0;
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            prod_q[0]  <= mul;
            valid_q[0] <= in_valid & ~clr;
            last_q[0]  <= in_last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i]  <= prod_q[i-1];
                valid_q[i] <= valid_q[i-1] & ~clr;
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign prod = prod_q[MUL_STAGES-1];
    assign mv   = valid_q[MUL_STAGES-1];
    assign ml   = last_q[MUL_STAGES-1];

endmodule

// File: rtl/mac_pe_sys.sv
// Systolic MAC processing element: forwards operands east/south, multiplies,
// accumulates until a last beat, then emits a converted result for one cycle.
module mac_pe_sys
    import mac_pkg::*;
#(
    parameter int DATA_W     = DATA_W_D,
    parameter int ACC_W      = ACC_W_D,
    parameter int OUT_W      = OUT_W_D,
    parameter int MUL_STAGES = 1,
    parameter int SATURATE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] w_in,
    input  logic [DATA_W-1:0] im_in,
    output logic [DATA_W-1:0] w_out,
    output logic [DATA_W-1:0] im_out,
    output logic              valid_out,
    output logic              last_out,
    output logic              clr_out,
    output logic [OUT_W-1:0]  p,
    output logic              p_valid,
    output logic              p_sat
);

    logic [2*DATA_W-1:0]     prod;
    logic                    mv;
    logic                    ml;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    conv_t                   conv;
    logic [CONV_W-1:OUT_W]   unused_conv_hi;

    mac_mul_pipe #(
        .DATA_W     (DATA_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_last  (in_last),
        .w_in     (w_in),
        .im_in    (im_in),
        .prod     (prod),
        .mv       (mv),
        .ml       (ml)
    );

    assign sum            = acc + ACC_W'($signed(prod));
    assign conv           = sat_conv(CONV_W'(sum), OUT_W, SATURATE != 0);
    assign unused_conv_hi = conv.value[CONV_W-1:OUT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_out     <= '0;
            im_out    <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            clr_out   <= 1'b0;
            acc       <= '0;
            p         <= '0;
            p_valid   <= 1'b0;
            p_sat     <= 1'b0;
        end else begin
            w_out     <= w_in;
            im_out    <= im_in;
            valid_out <= in_valid;
            last_out  <= in_last;
            clr_out   <= clr;
            // clr outranks a completing last beat; p keeps its previous result.
            if (clr) begin
                acc     <= '0;
                p_valid <= 1'b0;
            end else if (mv && ml) begin
                p       <= conv.value[OUT_W-1:0];
                p_valid <= 1'b1;
                p_sat   <= conv.clamped;
                acc     <= '0;
            end else begin
                if (mv) acc <= sum;
                p_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_pe_sys.sv
// Scoreboard bench: two PEs (default, and 3-stage truncating) share stimulus and
// are checked against a per-edge reference model of vector sums.
module tb_mac_pe_sys;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] w_in = '0;
    logic [31:0] im_in = '0;

    logic [31:0] a_w_out, a_im_out, a_p, b_w_out, b_im_out, b_p;
    logic        a_valid_out, a_last_out, a_clr_out, a_p_valid, a_p_sat;
    logic        b_valid_out, b_last_out, b_clr_out, b_p_valid, b_p_sat;

    mac_pe_sys dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
        .w_in(w_in), .im_in(im_in), .w_out(a_w_out), .im_out(a_im_out),
        .valid_out(a_valid_out), .last_out(a_last_out), .clr_out(a_clr_out),
        .p(a_p), .p_valid(a_p_valid), .p_sat(a_p_sat)
    );

    mac_pe_sys #(.MUL_STAGES(3), .SATURATE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
        .w_in(w_in), .im_in(im_in), .w_out(b_w_out), .im_out(b_im_out),
        .valid_out(b_valid_out), .last_out(b_last_out), .clr_out(b_clr_out),
        .p(b_p), .p_valid(b_p_valid), .p_sat(b_p_sat)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          edge_n;
        logic [31:0] p;
        logic        sat;
    } exp_t;

    localparam int     RING = 16;
    localparam longint HI   = 64'sh7FFFFFFF;
    localparam longint LO   = -64'sh80000000;

    bit     hv[RING], hl[RING], hc[RING];
    int     hw[RING], him[RING];
    int     edge_n = 0;
    int     rst_edge = 0;
    longint acc_m[2];
    int     stages[2] = '{1, 3};
    bit     satm[2] = '{1'b1, 1'b0};
    exp_t   q0[$], q1[$];

    function automatic exp_t conv_ref(longint s, bit sat, int en);
        exp_t x;
        x.edge_n = en;
        x.sat    = 1'b0;
        x.p      = 32'(s);
        if (sat && s > HI) begin
            x.p = 32'h7FFF_FFFF; x.sat = 1'b1;
        end else if (sat && s < LO) begin
            x.p = 32'h8000_0000; x.sat = 1'b1;
        end
        return x;
    endfunction

    // A beat sampled at edge src reaches the accumulator at edge src+stages and
    // survives only if no clr was sampled at any edge in between (inclusive).
    task automatic model_step(input int m);
        int     src;
        int     i;
        bit     take;
        longint s;
        exp_t   x;
        src  = edge_n - stages[m];
        take = (src > rst_edge) && hv[src % RING];
        if (take)
            for (int k = src; k <= edge_n; k++) if (hc[k % RING]) take = 1'b0;
        if (hc[edge_n % RING]) begin
            acc_m[m] = 0;
        end else if (take) begin
            i = src % RING;
            s = acc_m[m] + longint'(hw[i]) * longint'(him[i]);
            if (hl[i]) begin
                x = conv_ref(s, satm[m], edge_n);
                if (m == 0) q0.push_back(x); else q1.push_back(x);
                acc_m[m] = 0;
            end else begin
                acc_m[m] = s;
            end
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        hv[edge_n % RING]  = in_valid;
        hl[edge_n % RING]  = in_last;
        hc[edge_n % RING]  = clr;
        hw[edge_n % RING]  = w_in;
        him[edge_n % RING] = im_in;
        if (!rst_n) begin
            rst_edge = edge_n;
            acc_m[0] = 0;
            acc_m[1] = 0;
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- monitor ----------------
    exp_t xa, xb;

    always @(negedge clk) begin
        if (rst_n) begin
            while (q0.size() > 0 && q0[0].edge_n < edge_n) begin
                chk("a_missed_result_edge", 64'(edge_n), 64'(q0[0].edge_n));
                void'(q0.pop_front());
            end
            while (q1.size() > 0 && q1[0].edge_n < edge_n) begin
                chk("b_missed_result_edge", 64'(edge_n), 64'(q1[0].edge_n));
                void'(q1.pop_front());
            end
            if (a_p_valid) begin
                if (q0.size() == 0) chk("a_spurious_p_valid", 64'(a_p_valid), 64'd0);
                else begin
                    xa = q0.pop_front();
                    chk("a_p_edge", 64'(edge_n), 64'(xa.edge_n));
                    chk("a_p", 64'(a_p), 64'(xa.p));
                    chk("a_p_sat", 64'(a_p_sat), 64'(xa.sat));
                end
            end
            if (b_p_valid) begin
                if (q1.size() == 0) chk("b_spurious_p_valid", 64'(b_p_valid), 64'd0);
                else begin
                    xb = q1.pop_front();
                    chk("b_p_edge", 64'(edge_n), 64'(xb.edge_n));
                    chk("b_p", 64'(b_p), 64'(xb.p));
                    chk("b_p_sat", 64'(b_p_sat), 64'(xb.sat));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input bit l, input bit c, input int w, input int im);
        in_valid = v; in_last = l; clr = c; w_in = w; im_in = im;
        @(negedge clk);
        chk("a_fwd_data", {a_w_out, a_im_out}, {w, im});
        chk("a_fwd_ctl", 64'({a_valid_out, a_last_out, a_clr_out}), 64'({v, l, c}));
        chk("b_fwd_data", {b_w_out, b_im_out}, {w, im});
        chk("b_fwd_ctl", 64'({b_valid_out, b_last_out, b_clr_out}), 64'({v, l, c}));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    function automatic int rand_val();
        if ($urandom_range(0, 3) == 0) return int'($urandom());
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    initial begin
        // reset with random inputs: every output must stay 0
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom()); in_last = 1'($urandom()); clr = 1'($urandom());
            w_in = $urandom(); im_in = $urandom();
            @(negedge clk);
            chk("a_reset_fwd", {a_w_out, a_im_out}, 64'd0);
            chk("a_reset_ctl", 64'({a_valid_out, a_last_out, a_clr_out, a_p_valid, a_p_sat, a_p}), 64'd0);
            chk("b_reset_ctl", 64'({b_valid_out, b_last_out, b_clr_out, b_p_valid, b_p_sat, b_p}), 64'd0);
        end
        in_valid = 1'b0; in_last = 1'b0; clr = 1'b0; w_in = '0; im_in = '0;
        rst_n = 1'b1;

        step(1, 1, 0, 5, 7);                                  // forward + p=35
        idle(4);

        step(1, 0, 0, 3, 4); step(1, 0, 0, -2, 6); step(1, 1, 0, 10, 1);
        step(1, 1, 0, 1, 1);
        idle(4);

        step(1, 0, 0, 65536, 65536); step(1, 1, 0, 65536, 65536);
        step(1, 0, 0, -65536, 65536); step(1, 1, 0, -65536, 65536);
        idle(4);

        step(1, 1, 0, 2, 3); step(1, 1, 0, 4, 5); step(1, 1, 0, -1, -1);
        step(1, 0, 0, 1, 1); idle(2); step(1, 1, 0, 2, 2);
        idle(5);

        // clr lands exactly when the last beat is at dut_a's accumulator
        step(1, 0, 0, 7, 7); step(1, 1, 0, 1, 1); step(0, 0, 1, 0, 0);
        idle(5);
        chk("a_p_hold_after_clr", 64'(a_p), 64'd5);
        chk("b_p_hold_after_clr", 64'(b_p), 64'd5);
        step(1, 1, 0, 2, 2);
        idle(5);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, rand_val(), rand_val());
        idle(6);

        // asynchronous reset in the middle of a vector
        step(1, 0, 0, 3, 3); step(1, 0, 0, 4, 4);
        in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("a_midreset_p", 64'({a_p_valid, a_p}), 64'd0);
        chk("b_midreset_p", 64'({b_p_valid, b_p}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 1, 1);
        idle(8);

        chk("a_queue_drained", 64'(q0.size()), 64'd0);
        chk("b_queue_drained", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_pe_sys.md
Name: mac_pe_sys

Overview:
Parametrised successor of the single-lane accumulate PE, used as the processing element of the systolic MNIST array.
- Each cycle it registers and forwards its weight/image operands and control east/south.
- It multiplies operands signed through a configurable pipeline and accumulates vectors delimited by a last flag.
- On the last beat it emits a saturated or truncated result with a one-cycle valid pulse, then restarts accumulation automatically.

Parameters:
DATA_W, 32, signed operand width (w and im)
ACC_W, 64, accumulator width; must be >= 2*DATA_W
OUT_W, 32, result width; must be <= ACC_W
MUL_STAGES, 1, register stages in the multiplier, legal 1..3
SATURATE, 1, 1 = clamp result to signed OUT_W range; 0 = truncate to low OUT_W bits

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of accumulator and pipeline
in_valid  in  1  operand beat valid
in_last  in  1  beat is the final element of the current vector
w_in  in  DATA_W  signed weight
im_in  in  DATA_W  signed image value
w_out  out  DATA_W  w_in delayed 1 cycle (systolic forward)
im_out  out  DATA_W  im_in delayed 1 cycle
valid_out  out  1  in_valid delayed 1 cycle
last_out  out  1  in_last delayed 1 cycle
clr_out  out  1  clr delayed 1 cycle
p  out  OUT_W  last completed result
p_valid  out  1  one-cycle pulse, p updated this cycle
p_sat  out  1  qualifies p_valid: the result was clamped (always 0 when SATURATE=0)

Behaviour:
- Reset (rst_n low, asynchronous): every register is 0, including all outputs, the accumulator, and the pipeline data and valid/last bits. Deassertion takes effect at the next clk edge.
- Forward path:
  - w_out, im_out, valid_out, last_out and clr_out are plain 1-cycle registers.
  - They are unaffected by clr and have no gating.
- Multiply path:
  - Product width is 2*DATA_W signed, computed as $signed(w_in) * $signed(im_in).
  - The product travels with its valid and last bits through MUL_STAGES registers.
- Accumulate stage, on an edge where the pipeline-head valid bit (mv) is 1:
  - The stage computes sum = acc + sign-extended product, in ACC_W bits; overflow wraps modulo 2^ACC_W.
  - If the head last bit (ml) = 0: acc <= sum.
  - If ml = 1: p <= conv(sum), p_valid <= 1, p_sat <= clamp flag, acc <= 0.
- conv(), SATURATE=1:
  - If sum > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1.
  - If sum < -2^(OUT_W-1), the result is -2^(OUT_W-1).
  - Otherwise the result is sum[OUT_W-1:0].
- conv(), SATURATE=0: sum[OUT_W-1:0], and p_sat = 0.
- If mv = 0: acc holds and p_valid <= 0. p and p_sat hold their values (p_sat is meaningful only with p_valid).
- Latency: a beat with in_valid=in_last=1 at cycle t gives p_valid high in cycle t+MUL_STAGES+1.
- Throughput: one beat per cycle. A 1-element vector may follow a last beat immediately, so p_valid may be high on consecutive cycles.
- Gaps: in_valid=0 cycles inside a vector are bubbles; acc holds across them.
- in_last with in_valid=0 is ignored.
- clr, highest priority:
  - On the clr edge: acc <= 0, all multiplier-pipeline valid bits <= 0, p_valid <= 0.
  - p holds its value.
  - A beat presented in the same cycle as clr is dropped by this PE but still forwarded.
  - Beats presented the cycle after clr deasserts are accepted normally.
- clr and a completing last beat at the accumulate stage on the same edge: clr wins, and no p_valid is produced.
- Reset mid-vector: the partial sum is discarded and no spurious p_valid occurs after rst_n rises.

Decomposition:
- Package mac_pkg holds:
  - default width constants DATA_W_D=32, ACC_W_D=64, OUT_W_D=32;
  - the function sat_conv(sum, SATURATE) returning result and clamp flag.
- One natural sub-module, mac_mul_pipe:
  - a signed DATA_W x DATA_W multiplier;
  - MUL_STAGES registers carrying product, valid and last;
  - clr flushes its valid bits.
- mac_pe_sys instantiates mac_mul_pipe and contains the forward registers and the accumulate/output stage.

Test Plan:
- Reset/forwarding, defaults: hold rst_n=0 with random inputs -> all outputs 0. Release, apply w_in=5, im_in=7, valid=1 at cycle t -> w_out=5, im_out=7, valid_out=1 in cycle t+1.
- Basic vector: beats (3,4), (-2,6), (10,1) with last on the third at cycle t -> p=10 (12-12+10) and p_valid=1 at exactly t+2, p_sat=0. The next beat (1,1) with last gives p=1, proving acc was auto-cleared.
- Saturation: SATURATE=1, OUT_W=32: two beats (65536,65536) gives p=0x7FFFFFFF with p_sat=1. Beats (-65536,65536), (-65536,65536) gives p=0x80000000 with p_sat=1. With SATURATE=0 the first case gives p=0x00000000 with p_sat=0.
- Back-to-back and bubbles: three consecutive 1-element vectors (2,3), (4,5), (-1,-1) -> p_valid high for 3 consecutive cycles with p=6, 20, 1. Vector (1,1), bubble, bubble, (2,2) last -> p=5.
- clr collision: start vector (7,7), (1,1); assert clr in the cycle the last beat reaches the accumulate stage -> no p_valid and p unchanged. The next vector (2,2) last -> p=4.
- Latency sweep: MUL_STAGES=3 -> a single-beat last at t gives p_valid at t+4. Asynchronous reset pulsed mid-vector -> no p_valid afterwards; the next vector's result excludes earlier beats.
